rotor_stepper: RTL

- Upstream neighbour of the letter shifter. Holds three Enigma rotor positions, each in the range 0..25.
- Advances the positions odometer-style on each accepted keypress. The middle rotor double-steps.
- Produces the combined shift amount `rotor_value = (p0+p1+p2) mod 26`, which feeds the shifter's 7-bit rotor input.
- Initial rotor positions are loaded through a simple load port while the block is idle.

---
 rtl/rotor_stepper.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rotor_stepper.sv
// rotor_stepper: three-rotor Enigma position stepper with double-stepping
// middle rotor; emits registered (p0+p1+p2) mod 26 after each accepted key.
//
// Ports:
//   clock, resetn         clock, async active-low reset
//   load_en/sel/value     load one rotor position while idle
//   load_err              one-cycle pulse: load value out of range
//   key_valid/key_ready   keypress handshake (ready only when idle)
//   rotor_value           registered combined shift, 0..25
//   rotor_valid           one-cycle pulse when rotor_value is fresh
//   pos0, pos1, pos2      current rotor positions
module rotor_stepper #(
   parameter logic [4:0] NOTCH0 = 5'd16,
   parameter logic [4:0] NOTCH1 = 5'd4
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       load_en,
   input  logic [1:0] load_sel,
   input  logic [6:0] load_value,
   output logic       load_err,
   input  logic       key_valid,
   output logic       key_ready,
   output logic [6:0] rotor_value,
   output logic       rotor_valid,
   output logic [4:0] pos0,
   output logic [4:0] pos1,
   output logic [4:0] pos2
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] STEP = 2'd1;
   localparam logic [1:0] SUM  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0] state_q, state_d;
   logic [4:0] p0_q, p0_d;
   logic [4:0] p1_q, p1_d;
   logic [4:0] p2_q, p2_d;
   logic [6:0] rv_q, rv_d;
   logic       err_q, err_d;

   logic       step1, step2;
   logic [6:0] sum_raw;
   logic [6:0] sum_mod;

   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p == 5'd25) ? 5'd0 : p + 5'd1;
   endfunction

   // Middle rotor at its notch advances itself and the slow rotor:
   // this self-advance is the double step.
   assign step2 = (p1_q == NOTCH1);
   assign step1 = (p0_q == NOTCH0) || step2;

   assign sum_raw = {2'b00, p0_q} + {2'b00, p1_q} + {2'b00, p2_q};

   // Sum is at most 75, so two conditional subtractions suffice.
   always_comb begin
      sum_mod = sum_raw;
      if (sum_raw >= 7'd52) begin
         sum_mod = sum_raw - 7'd52;
      end else if (sum_raw >= 7'd26) begin
         sum_mod = sum_raw - 7'd26;
      end
   end

   always_comb begin
      state_d = state_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      rv_d    = rv_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_en) begin
               if (load_sel != 2'd3) begin
                  if (load_value > 7'd25) begin
                     err_d = 1'b1;
                  end else begin
                     case (load_sel)
                        2'd0:    p0_d = load_value[4:0];
                        2'd1:    p1_d = load_value[4:0];
                        default: p2_d = load_value[4:0];
                     endcase
                  end
               end
            end else if (key_valid) begin
               state_d = STEP;
            end
         end
         STEP: begin
            p0_d = inc26(p0_q);
            if (step1) p1_d = inc26(p1_q);
            if (step2) p2_d = inc26(p2_q);
            state_d = SUM;
         end
         SUM: begin
            rv_d    = sum_mod;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         p0_q    <= 5'd0;
         p1_q    <= 5'd0;
         p2_q    <= 5'd0;
         rv_q    <= 7'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
      end
   end

   assign key_ready   = (state_q == IDLE);
   assign rotor_valid = (state_q == DONE);
   assign rotor_value = rv_q;
   assign load_err    = err_q;
   assign pos0        = p0_q;
   assign pos1        = p1_q;
   assign pos2        = p2_q;

endmodule
